// File: rtl/arith_serial_engine.sv
// ---------------------------------------------------------------------------
// arith_serial_engine
// Bit-serial WIDTH-bit arithmetic unit. A single one-bit arithmetic slice
// (H = A ^ Y ^ C, Co = maj(A, Y, C)) is applied to one bit per clock, LSB
// first. The carry is held in a flop between bits.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   engine idle, request will be accepted
//   in_a/in_b  operands (WIDTH bits)
//   in_sel     {S1,S0}: 00 A+Cin, 01 A+B+Cin, 10 A-B-1+Cin, 11 A-1+Cin
//   in_cin     carry into bit 0
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_h      result (WIDTH bits)
//   out_cout   carry out of bit WIDTH-1
//   out_ovf    signed overflow; present only when ARITH_SERIAL_OVF_EN is defined
//
// Optional feature macro: ARITH_SERIAL_OVF_EN
// ---------------------------------------------------------------------------
module arith_serial_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_sel,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_h,
  output logic             out_cout
`ifdef ARITH_SERIAL_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [1:0]       sel_r;
  logic             carry;

  logic             y_c;
  logic             h_c;
  logic             co_c;

  // One-bit arithmetic slice on the current LSBs of the operand shifters.
  always_comb begin
    y_c = 1'b0;
    unique case (sel_r)
      2'b00:   y_c = 1'b0;
      2'b01:   y_c = b_sr[0];
      2'b10:   y_c = ~b_sr[0];
      default: y_c = 1'b1;
    endcase
    h_c  = a_sr[0] ^ y_c ^ carry;
    co_c = (a_sr[0] & y_c) | (a_sr[0] & carry) | (y_c & carry);
  end

  // Control FSM and datapath; out_h doubles as the result shift register,
  // filled from the top so bit 0 lands at the LSB after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sel_r     <= 2'b00;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_h     <= '0;
      out_cout  <= 1'b0;
`ifdef ARITH_SERIAL_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            sel_r    <= in_sel;
            carry    <= in_cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          out_h <= {h_c, out_h[WIDTH-1:1]};
          carry <= co_c;
          if (cnt == LAST_BIT) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            out_cout  <= co_c;
`ifdef ARITH_SERIAL_OVF_EN
            // carry register still holds the carry into the top bit here
            out_ovf   <= carry ^ co_c;
`endif
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_arith_serial_engine
// Scoreboard bench: the driver pushes the expected result of each accepted
// request (computed with plain integer arithmetic) and a monitor pops and
// compares on every output handshake, also checking latency and that the
// result is held steady under backpressure.
// ---------------------------------------------------------------------------
module tb_arith_serial_engine;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] h;
    logic             c;
    logic             v;
    int               acc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_sel;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_h;
  logic             out_cout;
`ifdef ARITH_SERIAL_OVF_EN
  logic             out_ovf;
`endif

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   bp_hold = 1'b0;
  exp_t q[$];

  arith_serial_engine #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_h     (out_h),
    .out_cout  (out_cout)
`ifdef ARITH_SERIAL_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // cyc holds the index of the most recent rising edge
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      cyc++;
      clk = 1'b1;
      #5;
      clk = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer add of A, the selected Y operand and Cin.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] sel, input logic cin);
    exp_t           e;
    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   t;
    case (sel)
      2'b00:   y = '0;
      2'b01:   y = b;
      2'b10:   y = ~b;
      default: y = '1;
    endcase
    t     = {1'b0, a} + {1'b0, y} + (WIDTH+1)'(cin);
    e.h   = t[WIDTH-1:0];
    e.c   = t[WIDTH];
    e.v   = (a[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    e.acc = 0;
    return e;
  endfunction

  // Drive a request, wait (bounded) for acceptance, push the expectation.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] sel, input logic cin);
    exp_t e;
    bit   ok;
    bit   r;
    ok = 1'b0;
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (i > 0) @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e     = model(a, b, sel, cin);
      e.acc = cyc;
      q.push_back(e);
    end else begin
      miscompares++;
      vectors++;
      $display("FAIL accept_timeout: in_ready never seen high");
    end
    #1;
    // scramble inputs: they must be ignored once captured
    in_valid = 1'b0;
    in_a     = WIDTH'($urandom);
    in_b     = WIDTH'($urandom);
    in_sel   = 2'($urandom);
    in_cin   = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
  endtask

  // Monitor: owns out_ready, checks latency, hold stability and results.
  initial begin : monitor
    bit prev_v;
    prev_v    = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        continue;
      end
      out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (out_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: out_valid=1 with no request outstanding");
        end else begin
          if (!prev_v) chk("latency", 32'(cyc - q[0].acc), 32'(WIDTH));
          else         chk("held_h", 32'(out_h), 32'(q[0].h));
          if (out_ready) begin
            exp_t e;
            e = q.pop_front();
            chk("out_h", 32'(out_h), 32'(e.h));
            chk("out_cout", 32'(out_cout), 32'(e.c));
`ifdef ARITH_SERIAL_OVF_EN
            chk("out_ovf", 32'(out_ovf), 32'(e.v));
`endif
          end
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  initial begin : main
    bit seen;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = '0;
    in_b     = '0;
    in_sel   = 2'b00;
    in_cin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_h", 32'(out_h), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;

    // directed vectors
    send(8'h3C, 8'h15, 2'b01, 1'b0);
    send(8'h10, 8'h01, 2'b10, 1'b1);
    send(8'h00, 8'hA5, 2'b11, 1'b0);
    send(8'hFF, 8'h5A, 2'b00, 1'b1);
`ifdef ARITH_SERIAL_OVF_EN
    send(8'h7F, 8'h01, 2'b01, 1'b0);
`endif
    drain();

    // backpressure: result held, no new accept while DONE
    @(posedge clk);
    bp_hold = 1'b1;
    send(8'hC3, 8'h3D, 2'b01, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    in_a     = 8'h11;
    in_b     = 8'h22;
    in_sel   = 2'b01;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    bp_hold = 1'b0;
    send(8'h11, 8'h22, 2'b01, 1'b0);
    drain();

    // reset during RUN at bit 3 aborts with no output
    send(8'h5A, 8'h33, 2'b01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_h", 32'(out_h), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // randomized operations with random gaps and random out_ready
    for (int n = 0; n < 60; n++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // boundary operands
    send(8'h80, 8'h01, 2'b10, 1'b0);
    send(8'hFF, 8'hFF, 2'b01, 1'b1);
    send(8'h00, 8'h00, 2'b10, 1'b0);
    drain();

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
